uart_cmd_host: RTL and testbench

- Host-side command initiator for the UART command protocol served by the system controller.
- Takes one parallel command request and serializes it into the protocol byte sequence through a byte-level UART transmitter.
- Collects the response bytes from a byte-level UART receiver and returns one assembled response with error and timeout status.
- Sits in the host/test-harness domain, wired to a UART TX/RX pair whose far end is the system's RX_IN/TX_OUT.

---
 rtl/uart_cmd_host.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// uart_cmd_host
// Host-side command initiator for the UART command protocol.
// It accepts one parallel command, sends its protocol bytes through a
// byte-level UART transmitter, collects the response bytes from a
// byte-level UART receiver, and returns one assembled response with
// error and timeout status.
//
// Ports:
//   REF_CLK, RST          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_type              0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
//   cmd_addr, cmd_wdata   register-file address / write data
//   cmd_op_a, cmd_op_b    ALU operands
//   cmd_fn                ALU function code
//   tx_data/tx_valid/tx_ready   byte stream toward the UART transmitter
//   rx_data/rx_valid/rx_err     byte pulses from the UART receiver
//   rsp_valid             one-cycle response strobe
//   rsp_data/rsp_err/rsp_timeout  response value and status (held)
//   busy                  high whenever the FSM is not in IDLE
module uart_cmd_host #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic        REF_CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_op_a,
    input  logic [7:0]  cmd_op_b,
    input  logic [7:0]  cmd_fn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam logic [1:0] CMD_RF_WR   = 2'd0;
    localparam logic [1:0] CMD_RF_RD   = 2'd1;
    localparam logic [1:0] CMD_ALU_OP  = 2'd2;
    localparam logic [1:0] CMD_ALU_NOP = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Protocol byte at position idx of a command frame.
    function automatic logic [7:0] byte_sel(
        input logic [1:0] t,
        input logic [1:0] idx,
        input logic [7:0] addr,
        input logic [7:0] wdata,
        input logic [7:0] op_a,
        input logic [7:0] op_b,
        input logic [7:0] fn
    );
        logic [7:0] b;
        b = 8'h00;
        case (t)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    b = 8'hAA;
                    2'd1:    b = addr;
                    default: b = wdata;
                endcase
            end
            CMD_RF_RD: begin
                b = (idx == 2'd0) ? 8'hBB : addr;
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    b = 8'hCC;
                    2'd1:    b = op_a;
                    2'd2:    b = op_b;
                    default: b = fn;
                endcase
            end
            default: begin
                b = (idx == 2'd0) ? 8'hDD : fn;
            end
        endcase
        return b;
    endfunction

    // Index of the final byte of a command frame.
    function automatic logic [1:0] last_idx(input logic [1:0] t);
        case (t)
            CMD_RF_WR:  return 2'd2;
            CMD_ALU_OP: return 2'd3;
            default:    return 2'd1;
        endcase
    endfunction

    // Number of response bytes a command expects.
    function automatic logic [1:0] rsp_count(input logic [1:0] t);
        case (t)
            CMD_RF_WR: return 2'd0;
            CMD_RF_RD: return 2'd1;
            default:   return 2'd2;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic [7:0]        fn_q, fn_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [1:0]        rx_idx_q, rx_idx_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic              err_flag_q, err_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Buffer contents as they will look after this cycle's rx byte.
    logic [7:0]        byte0_n, byte1_n;
    logic              err_n;
    logic [1:0]        rx_idx_n;

    // State register and all output registers.
    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            type_q        <= 2'd0;
            addr_q        <= 8'h00;
            wdata_q       <= 8'h00;
            op_a_q        <= 8'h00;
            op_b_q        <= 8'h00;
            fn_q          <= 8'h00;
            byte_idx_q    <= 2'd0;
            rx_idx_q      <= 2'd0;
            byte0_q       <= 8'h00;
            byte1_q       <= 8'h00;
            err_flag_q    <= 1'b0;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            fn_q          <= fn_d;
            byte_idx_q    <= byte_idx_d;
            rx_idx_q      <= rx_idx_d;
            byte0_q       <= byte0_d;
            byte1_q       <= byte1_d;
            err_flag_q    <= err_flag_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state and next-output logic. Response registers are loaded on
    // the transition into DONE so that rsp_valid is high exactly while the
    // FSM sits in DONE, one cycle after the final tx handshake or rx byte.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        fn_d          = fn_q;
        byte_idx_d    = byte_idx_q;
        rx_idx_d      = rx_idx_q;
        byte0_d       = byte0_q;
        byte1_d       = byte1_q;
        err_flag_d    = err_flag_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        byte0_n  = byte0_q;
        byte1_n  = byte1_q;
        err_n    = err_flag_q | rx_err;
        rx_idx_n = 2'(rx_idx_q + 2'd1);
        if (rx_idx_q == 2'd0) begin
            byte0_n = rx_data;
        end else begin
            byte1_n = rx_data;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    type_d     = cmd_type;
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    op_a_d     = cmd_op_a;
                    op_b_d     = cmd_op_b;
                    fn_d       = cmd_fn;
                    byte_idx_d = 2'd0;
                    rx_idx_d   = 2'd0;
                    byte0_d    = 8'h00;
                    byte1_d    = 8'h00;
                    err_flag_d = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = byte_sel(cmd_type, 2'd0, cmd_addr, cmd_wdata,
                                          cmd_op_a, cmd_op_b, cmd_fn);
                    state_d    = SEND;
                end
            end

            // A completed handshake drops tx_valid for one cycle; the
            // following cycle presents the next byte of the frame.
            SEND: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        if (byte_idx_q == last_idx(type_q)) begin
                            if (rsp_count(type_q) == 2'd0) begin
                                state_d       = DONE;
                                rsp_valid_d   = 1'b1;
                                rsp_data_d    = 16'h0000;
                                rsp_err_d     = err_flag_q;
                                rsp_timeout_d = 1'b0;
                            end else begin
                                state_d = WAIT_RSP;
                                cnt_d   = '0;
                            end
                        end else begin
                            byte_idx_d = 2'(byte_idx_q + 2'd1);
                        end
                    end
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = byte_sel(type_q, byte_idx_q, addr_q, wdata_q,
                                          op_a_q, op_b_q, fn_q);
                end
            end

            // An arriving byte takes priority over an expiring timeout.
            WAIT_RSP: begin
                if (rx_valid) begin
                    byte0_d    = byte0_n;
                    byte1_d    = byte1_n;
                    err_flag_d = err_n;
                    rx_idx_d   = rx_idx_n;
                    cnt_d      = '0;
                    if (rx_idx_n == rsp_count(type_q)) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = {byte1_n, byte0_n};
                        rsp_err_d     = err_n;
                        rsp_timeout_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = {byte1_q, byte0_q};
                    rsp_err_d     = err_flag_q;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// tb_uart_cmd_host
// Directed bench for uart_cmd_host. Each command pushes its expected
// protocol bytes and expected response onto scoreboard queues; monitors
// sampling on the falling clock edge pop and compare them as the DUT
// produces tx handshakes and response strobes, including response latency.
module tb_uart_cmd_host;

    localparam int T = 40;

    localparam logic [1:0] RF_WR   = 2'd0;
    localparam logic [1:0] RF_RD   = 2'd1;
    localparam logic [1:0] ALU_OP  = 2'd2;
    localparam logic [1:0] ALU_NOP = 2'd3;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        REF_CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_op_a;
    logic [7:0]  cmd_op_b;
    logic [7:0]  cmd_fn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_evt = 0;
    logic [7:0]  txq[$];
    rsp_t        rspq[$];
    rsp_t        mon_e;
    logic [7:0]  mon_b;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    bit          rand_ready = 1'b0;

    uart_cmd_host #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(16)
    ) dut (
        .REF_CLK(REF_CLK),
        .RST(RST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_op_a(cmd_op_a),
        .cmd_op_b(cmd_op_b),
        .cmd_fn(cmd_fn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_err(rx_err),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    // Free-running reference clock.
    initial begin
        REF_CLK = 1'b0;
        forever #5 REF_CLK = ~REF_CLK;
    end

    // Cycle counter used to time response strobes.
    always @(posedge REF_CLK) cyc <= cyc + 1;

    // Random backpressure on tx_ready while enabled.
    initial begin
        forever begin
            @(posedge REF_CLK);
            #1;
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // One comparison: counts it and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: tx byte order, tx stability under stall, and responses.
    always @(negedge REF_CLK) begin
        if (RST) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && tx_valid) begin
                checkOutput("tx_stable", 32'(tx_data), 32'(stall_data));
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                last_evt = cyc;
                checkOutput("tx_expected", 32'(txq.size() > 0), 32'd1);
                if (txq.size() > 0) begin
                    mon_b = txq.pop_front();
                    checkOutput("tx_byte", 32'(tx_data), 32'(mon_b));
                end
            end
            if (rx_valid) last_evt = cyc;
            if (rsp_valid) begin
                checkOutput("rsp_expected", 32'(rspq.size() > 0), 32'd1);
                if (rspq.size() > 0) begin
                    mon_e = rspq.pop_front();
                    checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
                    checkOutput("rsp_latency", 32'(cyc),
                                32'(last_evt + 1 + (mon_e.tmo ? T : 0)));
                end
            end
        end
    end

    // Issue one command, pushing its expected bytes (and response if any).
    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] fn,
                                 input logic [15:0] exp_data, input logic exp_err,
                                 input logic exp_tmo, input bit push_rsp);
        rsp_t e;
        case (t)
            RF_WR:   begin txq.push_back(8'hAA); txq.push_back(addr); txq.push_back(wdata); end
            RF_RD:   begin txq.push_back(8'hBB); txq.push_back(addr); end
            ALU_OP:  begin txq.push_back(8'hCC); txq.push_back(a); txq.push_back(b); txq.push_back(fn); end
            default: begin txq.push_back(8'hDD); txq.push_back(fn); end
        endcase
        if (push_rsp) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.tmo  = exp_tmo;
            rspq.push_back(e);
        end
        @(posedge REF_CLK);
        #1;
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_op_a  = a;
        cmd_op_b  = b;
        cmd_fn    = fn;
        @(posedge REF_CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_type  = ~t;
        cmd_addr  = 8'hFF;
        cmd_wdata = 8'hFF;
        cmd_op_a  = 8'hFF;
        cmd_op_b  = 8'hFF;
        cmd_fn    = 8'hFF;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic sendRx(input logic [7:0] d, input logic e);
        @(posedge REF_CLK);
        #1;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_err   = e;
        @(posedge REF_CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_err   = 1'b0;
        repeat (2) @(posedge REF_CLK);
    endtask

    task automatic waitTxDone(input int bound);
        for (int n = 0; n < bound && txq.size() != 0; n++) @(posedge REF_CLK);
        checkOutput("tx_drain", 32'(txq.size()), 32'd0);
    endtask

    task automatic waitRsp(input int bound);
        for (int n = 0; n < bound && rspq.size() != 0; n++) @(posedge REF_CLK);
        checkOutput("rsp_drain", 32'(rspq.size()), 32'd0);
    endtask

    initial begin
        $display("[TB] uart_cmd_host bench start");
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        cmd_op_a  = 8'h00;
        cmd_op_b  = 8'h00;
        cmd_fn    = 8'h00;
        tx_ready  = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        repeat (3) @(posedge REF_CLK);
        #1;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        RST = 1'b0;

        // RF_WR: no response bytes, strobe right after the last handshake.
        applyStimulus(RF_WR, 8'h07, 8'hAA, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
        waitTxDone(100);
        waitRsp(100);

        // RF_RD with one response byte.
        applyStimulus(RF_RD, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 16'h00AA, 1'b0, 1'b0, 1'b1);
        waitTxDone(100);
        sendRx(8'hAA, 1'b0);
        waitRsp(100);

        // ALU_OP then ALU_NOP, two response bytes each.
        applyStimulus(ALU_OP, 8'h00, 8'h00, 8'h07, 8'h08, 8'h00, 16'h000F, 1'b0, 1'b0, 1'b1);
        waitTxDone(100);
        sendRx(8'h0F, 1'b0);
        sendRx(8'h00, 1'b0);
        waitRsp(100);
        applyStimulus(ALU_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0016, 1'b0, 1'b0, 1'b1);
        waitTxDone(100);
        sendRx(8'h16, 1'b0);
        sendRx(8'h00, 1'b0);
        waitRsp(100);
        repeat (5) @(posedge REF_CLK);
        #1;
        checkOutput("rsp_hold_data", 32'(rsp_data), 32'h0016);
        checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'd0);

        // ALU_OP under random backpressure.
        rand_ready = 1'b1;
        applyStimulus(ALU_OP, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 16'h5544, 1'b0, 1'b0, 1'b1);
        waitTxDone(400);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        sendRx(8'h44, 1'b0);
        sendRx(8'h55, 1'b0);
        waitRsp(100);

        // RF_RD with no reply times out with empty data.
        applyStimulus(RF_RD, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1);
        waitTxDone(100);
        waitRsp(300);

        // ALU_OP with only one reply byte times out with partial data.
        applyStimulus(ALU_OP, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 16'h0024, 1'b0, 1'b1, 1'b1);
        waitTxDone(100);
        sendRx(8'h24, 1'b0);
        waitRsp(300);

        // rx_err on the second byte flags the response, data still assembled.
        applyStimulus(ALU_OP, 8'h00, 8'h00, 8'h05, 8'h03, 8'h01, 16'h0002, 1'b1, 1'b0, 1'b1);
        waitTxDone(100);
        sendRx(8'h02, 1'b0);
        sendRx(8'h00, 1'b1);
        waitRsp(100);

        // Stall in SEND well past the response timeout, then reset mid-frame.
        tx_ready = 1'b0;
        applyStimulus(RF_RD, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (T + 20) @(posedge REF_CLK);
        #1;
        checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("stall_tx_data", 32'(tx_data), 32'hBB);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        txq.delete();
        @(posedge REF_CLK);
        #1;
        RST      = 1'b0;
        tx_ready = 1'b1;

        // Normal command after the reset.
        applyStimulus(RF_RD, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 16'h005A, 1'b0, 1'b0, 1'b1);
        waitTxDone(100);
        sendRx(8'h5A, 1'b0);
        waitRsp(100);

        repeat (3) @(posedge REF_CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
